sc_ff: RTL and testbench

SC_FF -- requirements
Module: sc_ff

---
 rtl/sc_ff.sv | 62 ++++++
 tb/tb_sc_ff.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_ff.sv
// Mux-D scan register: parallel capture when se=0, serial shift from ScanIN toward Q[WIDTH-1] when se=1.
// Optional macro SC_FF_SE_REG_EN registers se internally so mode changes land one edge later.
module sc_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic [WIDTH-1:0] LogicIN,
  input  logic             ScanIN,
  input  logic             se,
  input  logic             CLK,
  input  logic             resetn,
  output logic [WIDTH-1:0] Q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic             se_eff;

`ifdef SC_FF_SE_REG_EN
  logic se_q;
  logic se_d;

  always_comb begin
    se_d = se;
  end

  always_ff @(posedge CLK) begin
    if (resetn) begin
      se_q <= 1'b0;
    end else begin
      se_q <= se_d;
    end
  end

  assign se_eff = se_q;
`else
  assign se_eff = se;
`endif

  // Shift moves every bit one place up; bit 0 takes ScanIN. With WIDTH=1 the loop is empty.
  always_comb begin
    r_d = LogicIN;
    if (se_eff) begin
      r_d[0] = ScanIN;
      for (int i = 1; i < WIDTH; i++) begin
        r_d[i] = r_q[i-1];
      end
    end
  end

  // resetn is active-high despite its name.
  always_ff @(posedge CLK) begin
    if (resetn) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= r_d;
    end
  end

  assign Q = r_q;

endmodule

// File: tb/tb_sc_ff.sv
// Bench for sc_ff: three instances (WIDTH 1, 4, 8) share clock, reset, se and ScanIN,
// checked against directed constants and a behavioural model of the register.
module tb_sc_ff;

`ifdef SC_FF_SE_REG_EN
  localparam int SE_LAG = 1;
`else
  localparam int SE_LAG = 0;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       se;
  logic       scan_in;
  logic       li1;
  logic [3:0] li4;
  logic [7:0] li8;
  logic       q1;
  logic [3:0] q4;
  logic [7:0] q8;

  always #5 clk = ~clk;

  sc_ff #(.WIDTH(1)) u1 (
    .LogicIN(li1), .ScanIN(scan_in), .se(se), .CLK(clk), .resetn(rst), .Q(q1)
  );
  sc_ff #(.WIDTH(4)) u4 (
    .LogicIN(li4), .ScanIN(scan_in), .se(se), .CLK(clk), .resetn(rst), .Q(q4)
  );
  sc_ff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u8 (
    .LogicIN(li8), .ScanIN(scan_in), .se(se), .CLK(clk), .resetn(rst), .Q(q8)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  logic       m1;
  logic [3:0] m4;
  logic [7:0] m8;
  logic       m_se_q;

  // Advance one rising edge, update the model from the values present at the edge, settle 1 time unit.
  task automatic step();
    logic se_eff;
    @(posedge clk);
    se_eff = (SE_LAG == 1) ? m_se_q : se;
    if (rst) begin
      m1     = 1'b0;
      m4     = 4'h0;
      m8     = 8'hA5;
      m_se_q = 1'b0;
    end else begin
      if (se_eff) begin
        m1 = scan_in;
        m4 = 4'((int'(m4) * 2 + int'(scan_in)) % 16);
        m8 = 8'((int'(m8) * 2 + int'(scan_in)) % 256);
      end else begin
        m1 = li1;
        m4 = li4;
        m8 = li8;
      end
      m_se_q = se;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; li1 = 1'b1; li4 = 4'hF; li8 = 8'hFF; scan_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      se = 1'($urandom_range(0, 1));
      step();
      n_cmp++;
      if (q1 !== 1'b0 || q4 !== 4'h0 || q8 !== 8'hA5) begin
        n_fail++;
        $display("FAIL reset_hold edge %0d: q1=%b q4=%h q8=%h expected 0/0/a5", k, q1, q4, q8);
      end
    end
    rst = 1'b0; se = 1'b0;
    #3;
    n_cmp++;
    if (q1 !== 1'b0 || q4 !== 4'h0 || q8 !== 8'hA5) begin
      n_fail++;
      $display("FAIL reset_between_edges: q1=%b q4=%h q8=%h expected 0/0/a5", q1, q4, q8);
    end
    step();
    n_cmp++;
    if (q1 !== 1'b1 || q4 !== 4'hF || q8 !== 8'hFF) begin
      n_fail++;
      $display("FAIL first_edge_after_reset: q1=%b q4=%h q8=%h expected 1/f/ff", q1, q4, q8);
    end
  endtask

  task automatic test_capture();
    logic       p1;
    logic [3:0] p4;
    logic [7:0] p8;
    do_reset();
    se = 1'b0;
    for (int k = 0; k < 16; k++) begin
      li1 = 1'((k / 2) % 2);
      li4 = 4'($urandom_range(0, 15));
      li8 = 8'($urandom_range(0, 255));
      scan_in = 1'($urandom_range(0, 1));
      p1 = li1; p4 = li4; p8 = li8;
      step();
      n_cmp++;
      if (q1 !== p1 || q4 !== p4 || q8 !== p8) begin
        n_fail++;
        $display("FAIL capture cyc %0d: q1=%b q4=%h q8=%h expected %b/%h/%h", k, q1, q4, q8, p1, p4, p8);
      end
    end
  endtask

  task automatic test_shift_w1();
    logic p;
    do_reset();
    se = 1'b1; li1 = 1'b0; li4 = 4'h0; li8 = 8'h0;
    repeat (SE_LAG) step();
    for (int k = 0; k < 12; k++) begin
      scan_in = 1'(k % 2);
      li1 = 1'($urandom_range(0, 1));
      p = scan_in;
      step();
      n_cmp++;
      if (q1 !== p) begin
        n_fail++;
        $display("FAIL shift_w1 cyc %0d: q1=%b expected %b", k, q1, p);
      end
    end
  endtask

  task automatic test_shift_w4();
    logic [3:0] bits;
    logic [3:0] emit;
    bits = 4'b1011;
    emit = 4'b1011;
    do_reset();
    se = 1'b1; scan_in = 1'b0; li1 = 1'b0; li4 = 4'h0; li8 = 8'h0;
    repeat (SE_LAG) step();
    for (int k = 0; k < 4; k++) begin
      scan_in = bits[3-k];
      step();
    end
    n_cmp++;
    if (q4 !== 4'b1011) begin
      n_fail++;
      $display("FAIL shift_w4_load: q4=%b expected 1011", q4);
    end
    scan_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_cmp++;
      if (q4[3] !== emit[3-k]) begin
        n_fail++;
        $display("FAIL shift_w4_out edge %0d: q4[3]=%b expected %b", k + 4, q4[3], emit[3-k]);
      end
    end
    // reset in the middle of a shift discards the partial data
    scan_in = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (q4 !== 4'h0 || q8 !== 8'hA5 || q1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_shift: q1=%b q4=%h q8=%h expected 0/0/a5", q1, q4, q8);
    end
  endtask

  task automatic test_capture_then_shift();
    logic [3:0] emit;
    emit = 4'b1010;
    do_reset();
    se = 1'b0; li4 = 4'hA; li1 = 1'b1; li8 = 8'h3C; scan_in = 1'b1;
    step();
    n_cmp++;
    if (q4 !== 4'hA) begin
      n_fail++;
      $display("FAIL capture_a: q4=%h expected a", q4);
    end
    se = 1'b1; scan_in = 1'b0;
    repeat (SE_LAG) step();
    for (int k = 0; k < 4; k++) begin
      if (k > 0) step();
      n_cmp++;
      if (q4[3] !== emit[3-k]) begin
        n_fail++;
        $display("FAIL capture_shift_out %0d: q4[3]=%b expected %b", k, q4[3], emit[3-k]);
      end
    end
  endtask

  task automatic test_se_timing();
    do_reset();
    se = 1'b0; li1 = 1'b0; scan_in = 1'b1; li4 = 4'h0; li8 = 8'h0;
    step();
    se = 1'b1;
    step();
`ifdef SC_FF_SE_REG_EN
    n_cmp++;
    if (q1 !== 1'b0) begin
      n_fail++;
      $display("FAIL se_reg_edge_n: q1=%b expected 0", q1);
    end
    step();
    n_cmp++;
    if (q1 !== 1'b1) begin
      n_fail++;
      $display("FAIL se_reg_edge_n1: q1=%b expected 1", q1);
    end
`else
    n_cmp++;
    if (q1 !== 1'b1) begin
      n_fail++;
      $display("FAIL se_direct_edge_n: q1=%b expected 1", q1);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 300; k++) begin
      rst     = ($urandom_range(0, 15) == 0);
      se      = 1'($urandom_range(0, 1));
      scan_in = 1'($urandom_range(0, 1));
      li1     = 1'($urandom_range(0, 1));
      li4     = 4'($urandom_range(0, 15));
      li8     = 8'($urandom_range(0, 255));
      step();
      n_cmp++;
      if (q1 !== m1 || q4 !== m4 || q8 !== m8) begin
        n_fail++;
        $display("FAIL random cyc %0d: q1=%b q4=%h q8=%h expected %b/%h/%h", k, q1, q4, q8, m1, m4, m8);
      end
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; se = 1'b0; scan_in = 1'b0; li1 = 1'b0; li4 = 4'h0; li8 = 8'h0;
    m1 = 1'b0; m4 = 4'h0; m8 = 8'h0; m_se_q = 1'b0;
    test_reset();
    test_capture();
    test_shift_w1();
    test_shift_w4();
    test_capture_then_shift();
    test_se_timing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
